gate_eval_arbiter: RTL and testbench

Shares one bitwise logic-evaluation unit (AND, OR, NOT, NAND, NOR of X and Y) among NUM_REQ requesters. A round-robin arbiter grants one request per cycle. The selected operation is computed and captured in a single-entry output register, and results return over a valid/ready response channel tagged with the requester ID. The block sits between requester blocks and the shared gate datapath.

---
 rtl/gate_eval_arbiter.sv | 105 ++++++++++
 tb/tb_gate_eval_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_eval_arbiter.sv
// Round-robin arbiter that shares one bitwise gate-evaluation unit among NUM_REQ
// requesters and returns tagged results through a single-entry output register.
module gate_eval_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 1,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [3*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_x,
    input  logic [DATA_W*NUM_REQ-1:0] req_y,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state, state_next;
    logic [ID_W-1:0]   rr_ptr, rr_next, sel;
    logic              found, can_accept, transfer;
    logic [2:0]        sel_op;
    logic [DATA_W-1:0] sel_x, sel_y, result;
    logic              illegal;
    int                idx;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
    end

    assign can_accept = !rsp_valid || rsp_ready;
    assign transfer   = found && can_accept;
    // Explicit wrap keeps the pointer legal when NUM_REQ is not a power of two.
    assign rr_next    = (int'(sel) == NUM_REQ - 1) ? '0 : sel + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (transfer) req_ready[sel] = 1'b1;
    end

    assign sel_op = req_op[3*int'(sel) +: 3];
    assign sel_x  = req_x[DATA_W*int'(sel) +: DATA_W];
    assign sel_y  = req_y[DATA_W*int'(sel) +: DATA_W];

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (sel_op)
            3'd0:    result = sel_x & sel_y;
            3'd1:    result = sel_x | sel_y;
            3'd2:    result = ~sel_x;
            3'd3:    result = ~(sel_x & sel_y);
            3'd4:    result = ~(sel_x | sel_y);
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (transfer) state_next = FULL;
            FULL:    if (rsp_ready && !transfer) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    assign rsp_valid = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (transfer) begin
            rr_ptr   <= rr_next;
            rsp_id   <= sel;
            rsp_data <= result;
            rsp_err  <= illegal;
        end
    end

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Self-checking bench for gate_eval_arbiter: a per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_gate_eval_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 1;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [3*NUM_REQ-1:0]      req_op = '0;
    logic [DATA_W*NUM_REQ-1:0] req_x = '0;
    logic [DATA_W*NUM_REQ-1:0] req_y = '0;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b1;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;

    int errors = 0;
    int checks = 0;

    gate_eval_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pointer, output slot and result computed from the opcode table.
    int                m_rr   = 0;
    logic              m_full = 1'b0;
    int                m_id   = 0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_err  = 1'b0;

    function automatic int model_grant();
        if (m_full && !rsp_ready) return -1;
        for (int k = 0; k < NUM_REQ; k++)
            if (req_valid[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [DATA_W:0] model_eval(input int i);
        logic [2:0]        op;
        logic [DATA_W-1:0] x, y;
        op = req_op[3*i +: 3];
        x  = req_x[DATA_W*i +: DATA_W];
        y  = req_y[DATA_W*i +: DATA_W];
        case (op)
            3'd0:    return {1'b0, x & y};
            3'd1:    return {1'b0, x | y};
            3'd2:    return {1'b0, ~x};
            3'd3:    return {1'b0, ~(x & y)};
            3'd4:    return {1'b0, ~(x | y)};
            default: return {1'b1, {DATA_W{1'b0}}};
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rr   <= 0;
            m_full <= 1'b0;
        end else begin
            int g;
            logic [DATA_W:0] r;
            g = model_grant();
            if (g >= 0) begin
                r = model_eval(g);
                m_full <= 1'b1;
                m_id   <= g;
                m_data <= r[DATA_W-1:0];
                m_err  <= r[DATA_W];
                m_rr   <= (g + 1) % NUM_REQ;
            end else if (rsp_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [NUM_REQ-1:0] exp_ready;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("model_req_ready", 32'(req_ready), 32'(exp_ready));
        check("model_rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            check("model_rsp_id", 32'(rsp_id), 32'(m_id));
            check("model_rsp_data", 32'(rsp_data), 32'(m_data));
            check("model_rsp_err", 32'(rsp_err), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic x, input logic y);
        req_valid[i]           = 1'b1;
        req_op[3*i +: 3]       = op;
        req_x[DATA_W*i +: DATA_W] = DATA_W'(x);
        req_y[DATA_W*i +: DATA_W] = DATA_W'(y);
    endtask

    logic [3:0]  tt [5];
    int          exp_seq [6];
    logic [DATA_W-1:0] held_data;

    initial begin
        tt      = '{4'b0001, 4'b0111, 4'b1100, 4'b1110, 4'b1000};
        exp_seq = '{0, 1, 2, 3, 0, 1};

        step(); step();
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_id", 32'(rsp_id), 0);
        check("reset_rsp_data", 32'(rsp_data), 0);
        check("reset_rsp_err", 32'(rsp_err), 0);
        rst = 1'b0;
        step();

        // Single request
        set_req(0, 3'd0, 1'b1, 1'b1);
        rsp_ready = 1'b1;
        #1 check("single_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        check("single_rsp_valid", 32'(rsp_valid), 1);
        check("single_rsp_id", 32'(rsp_id), 0);
        check("single_rsp_data", 32'(rsp_data), 1);
        check("single_rsp_err", 32'(rsp_err), 0);
        step();

        // Reset while a result is held under backpressure
        set_req(1, 3'd1, 1'b0, 1'b1);
        rsp_ready = 1'b0;
        step();
        req_valid = '0;
        check("midrst_held_valid", 32'(rsp_valid), 1);
        #2 rst = 1'b1;
        #1 check("midrst_rsp_valid", 32'(rsp_valid), 0);
        #3 rst = 1'b0;
        step();
        set_req(3, 3'd3, 1'b1, 1'b0);
        set_req(0, 3'd4, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        #1 check("postrst_grant0", 32'(req_ready), 32'h1);
        step();
        check("postrst_rsp_id0", 32'(rsp_id), 0);
        check("postrst_nor", 32'(rsp_data), 1);
        step();
        check("postrst_rsp_id3", 32'(rsp_id), 3);
        check("postrst_nand", 32'(rsp_data), 1);
        req_valid = '0;
        step();

        // Fairness, all requesters valid
        set_req(0, 3'd0, 1'b1, 1'b0);
        set_req(1, 3'd1, 1'b1, 1'b0);
        set_req(2, 3'd2, 1'b1, 1'b0);
        set_req(3, 3'd3, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            check("fair_rsp_valid", 32'(rsp_valid), 1);
            check("fair_rsp_id", 32'(rsp_id), 32'(exp_seq[k]));
        end

        // Backpressure
        rsp_ready = 1'b0;
        held_data = rsp_data;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_req_ready", 32'(req_ready), 0);
            step();
            check("bp_rsp_id", 32'(rsp_id), 1);
            check("bp_rsp_data", 32'(rsp_data), 32'(held_data));
        end
        rsp_ready = 1'b1;
        #1 check("bp_release_grant", 32'(req_ready), 32'h4);
        step();
        check("bp_next_id", 32'(rsp_id), 2);
        req_valid = '0;
        step();

        // Illegal opcode
        set_req(2, 3'd6, 1'b1, 1'b1);
        step();
        req_valid = '0;
        check("illegal_rsp_id", 32'(rsp_id), 2);
        check("illegal_rsp_data", 32'(rsp_data), 0);
        check("illegal_rsp_err", 32'(rsp_err), 1);

        // Mixed request pattern, covered by the model
        set_req(1, 3'd1, 1'b0, 1'b0);
        set_req(3, 3'd7, 1'b1, 1'b1);
        step(); step(); step();
        req_valid = '0;
        step();

        // Truth table, back-to-back on requester 1
        for (int op = 0; op < 5; op++) begin
            for (int xy = 0; xy < 4; xy++) begin
                set_req(1, 3'(op), xy[1], xy[0]);
                step();
                check($sformatf("tt_op%0d_xy%0d", op, xy), 32'(rsp_data), 32'(tt[op][3-xy]));
                check("tt_rsp_err", 32'(rsp_err), 0);
            end
        end
        req_valid = '0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
